// File: rtl/ledr_pkg.sv
// Shared constants for the LEDR PWM/blink stage: register map, CTRL fields, reset values.
package ledr_pkg;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_MASK   = 2'd1;
    localparam logic [1:0] ADDR_HALF   = 2'd2;
    localparam logic [1:0] ADDR_STATUS = 2'd3;

    localparam int unsigned CTRL_BRIGHT_LSB = 0;
    localparam int unsigned CTRL_BRIGHT_W   = 8;
    localparam int unsigned CTRL_EN_BIT     = 8;

    localparam logic [7:0] BRIGHT_RST = 8'hFF;
    localparam logic       EN_RST     = 1'b1;
    localparam logic [7:0] PWM_MAX    = 8'hFF;

    // Blink phase states; PHASE_ON lets masked LEDs follow led_in.
    localparam logic PHASE_ON  = 1'b1;
    localparam logic PHASE_OFF = 1'b0;

    function automatic logic pwm_level(input logic [7:0] cnt, input logic [7:0] bright);
        return (bright == PWM_MAX) || (cnt < bright);
    endfunction

endpackage

// File: rtl/ledr_pwm_blinker_if.sv
// Avalon-MM slave bus of the LEDR PWM/blink stage (4 word registers, read latency 0).
interface ledr_pwm_blinker_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface

// File: rtl/ledr_pwm_timebase.sv
// Prescaler, 8-bit PWM counter, frame pulse and blink phase generator.
module ledr_pwm_timebase
    import ledr_pkg::*;
#(
    parameter int unsigned PRESCALE_DIV = 50,
    parameter int unsigned BLINK_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [7:0]         bright,
    input  logic [BLINK_W-1:0] half,
    input  logic               half_wr,
    output logic [7:0]         pwm_cnt,
    output logic               pwm_on,
    output logic               blink_phase
);

    localparam int unsigned PRE_W = $clog2(PRESCALE_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE_DIV - 1);

    logic [PRE_W-1:0]   pre_cnt_q, pre_cnt_d;
    logic [7:0]         pwm_cnt_q, pwm_cnt_d;
    logic [BLINK_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               tick;
    logic               frame;

    assign tick  = (pre_cnt_q == PRE_LAST);
    assign frame = tick && (pwm_cnt_q == PWM_MAX);

    always_comb begin
        pre_cnt_d     = tick ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d     = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        blink_phase_d = blink_phase_q;
        // A BLINK_HALF write restarts the blink cycle and wins over a coincident toggle.
        if (half_wr || (half == '0)) begin
            frame_cnt_d   = '0;
            blink_phase_d = PHASE_ON;
        end else if (frame) begin
            if (frame_cnt_q == half - BLINK_W'(1)) begin
                frame_cnt_d   = '0;
                blink_phase_d = (blink_phase_q == PHASE_ON) ? PHASE_OFF : PHASE_ON;
            end else begin
                frame_cnt_d = frame_cnt_q + BLINK_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q     <= '0;
            pwm_cnt_q     <= '0;
            frame_cnt_q   <= '0;
            blink_phase_q <= PHASE_ON;
        end else begin
            pre_cnt_q     <= pre_cnt_d;
            pwm_cnt_q     <= pwm_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    assign pwm_cnt     = pwm_cnt_q;
    assign pwm_on      = pwm_level(pwm_cnt_q, bright);
    assign blink_phase = blink_phase_q;

endmodule

// File: rtl/ledr_pwm_blinker.sv
// LEDR output stage: Avalon register file, read mux and registered PWM/blink gating of led_in.
module ledr_pwm_blinker
    import ledr_pkg::*;
#(
    parameter int unsigned LED_W        = 18,
    parameter int unsigned PRESCALE_DIV = 50,
    parameter int unsigned BLINK_W      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    ledr_pwm_blinker_if.slave    avs,
    input  logic [LED_W-1:0]     led_in,
    output logic [LED_W-1:0]     ledr
);

    logic [7:0]         bright_q, bright_d;
    logic               en_q, en_d;
    logic [LED_W-1:0]   mask_q, mask_d;
    logic [BLINK_W-1:0] half_q, half_d;

    logic               wr;
    logic               half_wr;
    logic [7:0]         pwm_cnt;
    logic               pwm_on;
    logic               blink_phase;
    logic               unused_wdata;

    assign wr           = avs.chipselect && !avs.write_n;
    assign half_wr      = wr && (avs.address == ADDR_HALF);
    assign unused_wdata = ^avs.writedata;

    always_comb begin
        bright_d = bright_q;
        en_d     = en_q;
        mask_d   = mask_q;
        half_d   = half_q;
        if (wr) begin
            case (avs.address)
                ADDR_CTRL: begin
                    bright_d = avs.writedata[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W];
                    en_d     = avs.writedata[CTRL_EN_BIT];
                end
                ADDR_MASK: mask_d = avs.writedata[LED_W-1:0];
                ADDR_HALF: half_d = avs.writedata[BLINK_W-1:0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bright_q <= BRIGHT_RST;
            en_q     <= EN_RST;
            mask_q   <= '0;
            half_q   <= '0;
        end else begin
            bright_q <= bright_d;
            en_q     <= en_d;
            mask_q   <= mask_d;
            half_q   <= half_d;
        end
    end

    ledr_pwm_timebase #(
        .PRESCALE_DIV (PRESCALE_DIV),
        .BLINK_W      (BLINK_W)
    ) u_timebase (
        .clk         (clk),
        .reset_n     (reset_n),
        .bright      (bright_q),
        .half        (half_q),
        .half_wr     (half_wr),
        .pwm_cnt     (pwm_cnt),
        .pwm_on      (pwm_on),
        .blink_phase (blink_phase)
    );

    always_comb begin
        avs.readdata = '0;
        case (avs.address)
            ADDR_CTRL: begin
                avs.readdata[CTRL_BRIGHT_LSB +: CTRL_BRIGHT_W] = bright_q;
                avs.readdata[CTRL_EN_BIT]                      = en_q;
            end
            ADDR_MASK: avs.readdata[LED_W-1:0]   = mask_q;
            ADDR_HALF: avs.readdata[BLINK_W-1:0] = half_q;
            ADDR_STATUS: begin
                avs.readdata[0]    = blink_phase;
                avs.readdata[15:8] = pwm_cnt;
            end
            default: avs.readdata = '0;
        endcase
    end

    // Masked LEDs are blanked during the off phase; unmasked ones only see PWM and enable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ledr <= '0;
        end else if (en_q) begin
            ledr <= led_in & {LED_W{pwm_on}} & (~mask_q | {LED_W{blink_phase}});
        end else begin
            ledr <= '0;
        end
    end

endmodule

// File: tb/tb_ledr_pwm_blinker.sv
// Randomized bench for ledr_pwm_blinker against a time-indexed arithmetic model.
module tb_ledr_pwm_blinker;

    localparam int LED_W   = 18;
    localparam int P       = 2;
    localparam int BLINK_W = 16;
    localparam int FRAME   = 256 * P;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [LED_W-1:0] led_in;
    logic [LED_W-1:0] ledr;

    ledr_pwm_blinker_if bus ();

    ledr_pwm_blinker #(
        .LED_W        (LED_W),
        .PRESCALE_DIV (P),
        .BLINK_W      (BLINK_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .avs     (bus),
        .led_in  (led_in),
        .ledr    (ledr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: k = clock edges since reset release, anchor = edge of the last BLINK_HALF write.
    int               k;
    int               anchor;
    logic [7:0]       m_bright;
    logic             m_en;
    logic [LED_W-1:0] m_mask;
    logic [15:0]      m_half;
    logic [LED_W-1:0] exp_ledr;

    function automatic int m_pwm(int kk);
        return (kk / P) % 256;
    endfunction

    function automatic logic m_phase(int kk);
        int frames;
        if (m_half == 16'd0) return 1'b1;
        frames = kk / FRAME - anchor / FRAME;
        return ((frames / int'(m_half)) % 2) == 0;
    endfunction

    function automatic logic [LED_W-1:0] m_ledr_next(int kk, logic [LED_W-1:0] din);
        logic on;
        on = (m_bright == 8'hFF) || (m_pwm(kk) < int'(m_bright));
        if (!m_en || !on) return '0;
        return din & ~(m_mask & {LED_W{~m_phase(kk)}});
    endfunction

    function automatic logic [31:0] m_read(logic [1:0] a);
        logic [31:0] r;
        r = '0;
        case (a)
            2'd0:    r = {23'd0, m_en, m_bright};
            2'd1:    r[LED_W-1:0] = m_mask;
            2'd2:    r[15:0] = m_half;
            default: begin
                r[15:8] = 8'(m_pwm(k));
                r[0]    = m_phase(k);
            end
        endcase
        return r;
    endfunction

    task automatic model_reset();
        k        = 0;
        anchor   = 0;
        m_bright = 8'hFF;
        m_en     = 1'b1;
        m_mask   = '0;
        m_half   = '0;
        exp_ledr = '0;
    endtask

    task automatic clk_step();
        logic [LED_W-1:0] nxt;
        logic             wr;
        logic [1:0]       a;
        logic [31:0]      d;
        nxt = m_ledr_next(k, led_in);
        wr  = bus.chipselect && !bus.write_n;
        a   = bus.address;
        d   = bus.writedata;
        @(posedge clk);
        #1;
        k++;
        exp_ledr = nxt;
        if (wr) begin
            case (a)
                2'd0: begin
                    m_bright = d[7:0];
                    m_en     = d[8];
                end
                2'd1: m_mask = d[LED_W-1:0];
                2'd2: begin
                    m_half = d[15:0];
                    anchor = k;
                end
                default: ;
            endcase
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        bus.address    = a;
        bus.writedata  = d;
        bus.chipselect = 1'b1;
        bus.write_n    = 1'b0;
        clk_step();
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] exp;
        reset_n = 1'b0;
        led_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (ledr !== '0) begin
            errors++;
            $display("FAIL reset_ledr: got %h expected 0", ledr);
        end
        for (int a = 0; a < 4; a++) begin
            bus.address = 2'(a);
            #1;
            exp = (a == 0) ? 32'h1FF : (a == 3) ? 32'h1 : 32'h0;
            checks++;
            if (bus.readdata !== exp) begin
                errors++;
                $display("FAIL reset_read%0d: got %h expected %h", a, bus.readdata, exp);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_passthrough();
        int bad;
        led_in = 18'h2AAAA;
        clk_step();
        checks++;
        if (ledr !== 18'h2AAAA) begin
            errors++;
            $display("FAIL passthrough_first: got %h expected 2aaaa", ledr);
        end
        bad = 0;
        repeat (40) begin
            led_in = LED_W'($urandom);
            clk_step();
            if (ledr !== exp_ledr) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL passthrough_random: got %0d bad cycles expected 0", bad);
        end
    endtask

    task automatic test_brightness();
        int bad;
        int high;
        logic [LED_W-1:0] bad_got, bad_exp;
        led_in = '1;
        bus_write(2'd0, 32'h140);
        bad  = 0;
        high = 0;
        bad_got = '0;
        bad_exp = '0;
        repeat (1024) begin
            clk_step();
            if (ledr[0]) high++;
            bus.address = 2'd3;
            #1;
            if (ledr !== exp_ledr || bus.readdata !== m_read(2'd3)) begin
                if (bad == 0) begin
                    bad_got = ledr;
                    bad_exp = exp_ledr;
                end
                bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bright64_trace: %0d bad cycles, first ledr=%h expected %h",
                     bad, bad_got, bad_exp);
        end
        checks++;
        if (high != 256) begin
            errors++;
            $display("FAIL bright64_duty: got %0d high cycles expected 256", high);
        end

        bad = 0;
        repeat (6) begin
            bus_write(2'd0, {23'd0, 1'b1, 8'($urandom)});
            repeat (200) begin
                led_in = LED_W'($urandom);
                clk_step();
                if (ledr !== exp_ledr) bad++;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bright_random: got %0d bad cycles expected 0", bad);
        end

        led_in = '1;
        bus_write(2'd0, 32'h100);
        clk_step();
        bad = 0;
        repeat (600) begin
            clk_step();
            if (ledr !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bright0_dark: got %0d lit cycles expected 0", bad);
        end
    endtask

    task automatic test_blink();
        int bad;
        int toggles;
        int bad_int;
        int last;
        int n;
        logic prev;
        led_in = '1;
        bus_write(2'd0, 32'h1FF);
        bus_write(2'd1, 32'h1);
        bus_write(2'd2, 32'h2);
        clk_step();
        checks++;
        if (ledr[0] !== 1'b1) begin
            errors++;
            $display("FAIL blink_start: got ledr[0]=%b expected 1", ledr[0]);
        end
        bad = 0;
        toggles = 0;
        bad_int = 0;
        last = -1;
        n = 0;
        prev = ledr[0];
        repeat (4200) begin
            clk_step();
            n++;
            bus.address = 2'd3;
            #1;
            if (ledr !== exp_ledr || ledr[LED_W-1:1] !== '1 ||
                bus.readdata !== m_read(2'd3)) bad++;
            if (ledr[0] !== prev) begin
                if (last >= 0 && n - last != 1024) bad_int++;
                last = n;
                toggles++;
                prev = ledr[0];
            end
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL blink_trace: got %0d bad cycles expected 0", bad);
        end
        checks++;
        if (toggles < 3 || bad_int != 0) begin
            errors++;
            $display("FAIL blink_period: got %0d toggles, %0d wrong intervals, expected >=3 and 0",
                     toggles, bad_int);
        end
    endtask

    task automatic test_blink_restart();
        int guard;
        int n;
        int bad;
        guard = 0;
        while (!(m_phase(k) == 1'b1 && m_phase(k + 1) == 1'b0) && guard < 5000) begin
            clk_step();
            guard++;
        end
        checks++;
        if (guard >= 5000) begin
            errors++;
            $display("FAIL restart_find: got no due toggle within %0d cycles expected one", guard);
        end
        bus_write(2'd2, 32'h3);
        bus.address = 2'd3;
        #1;
        checks++;
        if (bus.readdata[0] !== 1'b1) begin
            errors++;
            $display("FAIL restart_phase: got %b expected 1", bus.readdata[0]);
        end
        n = 0;
        bad = 0;
        while (bus.readdata[0] === 1'b1 && n < 2000) begin
            clk_step();
            n++;
            bus.address = 2'd3;
            #1;
            if (ledr !== exp_ledr) bad++;
        end
        checks++;
        if (n != 3 * FRAME || bad != 0) begin
            errors++;
            $display("FAIL restart_period: got %0d cycles (%0d bad) expected %0d (0)",
                     n, bad, 3 * FRAME);
        end
    endtask

    task automatic test_enable();
        logic [31:0] d;
        int bad;
        led_in = LED_W'($urandom) | 18'h1;
        bus_write(2'd0, 32'h0FF);
        clk_step();
        checks++;
        if (ledr !== '0) begin
            errors++;
            $display("FAIL enable_off: got %h expected 0", ledr);
        end
        bad = 0;
        repeat (5) begin
            led_in = LED_W'($urandom);
            repeat (3) clk_step();
            bus.address = 2'd3;
            #1;
            if (bus.readdata !== m_read(2'd3) || ledr !== '0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL enable_counting: got %0d bad samples expected 0", bad);
        end
        d = $urandom;
        bus_write(2'd3, d);
        for (int a = 0; a < 3; a++) begin
            bus.address = 2'(a);
            #1;
            checks++;
            if (bus.readdata !== m_read(2'(a))) begin
                errors++;
                $display("FAIL status_write_ignored%0d: got %h expected %h",
                         a, bus.readdata, m_read(2'(a)));
            end
        end
        bus.address = 2'd0;
        #1;
        checks++;
        if (bus.readdata !== 32'h0FF) begin
            errors++;
            $display("FAIL ctrl_after_status_write: got %h expected 000000ff", bus.readdata);
        end
        bus_write(2'd0, 32'h1FF);
    endtask

    task automatic test_async_reset();
        int guard;
        int bad;
        logic [31:0] exp;
        led_in = '1;
        guard = 0;
        while (m_phase(k) != 1'b0 && guard < 5000) begin
            clk_step();
            guard++;
        end
        repeat (3) clk_step();
        checks++;
        if (ledr !== exp_ledr || ledr === '0) begin
            errors++;
            $display("FAIL pre_reset_ledr: got %h expected %h (nonzero)", ledr, exp_ledr);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (ledr !== '0) begin
            errors++;
            $display("FAIL async_reset_ledr: got %h expected 0", ledr);
        end
        for (int a = 0; a < 4; a++) begin
            bus.address = 2'(a);
            #1;
            exp = (a == 0) ? 32'h1FF : (a == 3) ? 32'h1 : 32'h0;
            checks++;
            if (bus.readdata !== exp) begin
                errors++;
                $display("FAIL async_reset_read%0d: got %h expected %h", a, bus.readdata, exp);
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        bad = 0;
        repeat (50) begin
            led_in = LED_W'($urandom);
            clk_step();
            bus.address = 2'd3;
            #1;
            if (ledr !== exp_ledr || bus.readdata !== m_read(2'd3)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL post_reset_trace: got %0d bad cycles expected 0", bad);
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        led_in         = '0;
        bus.address    = 2'd0;
        bus.chipselect = 1'b0;
        bus.write_n    = 1'b1;
        bus.writedata  = '0;
        model_reset();
        test_reset();
        test_passthrough();
        test_brightness();
        test_blink();
        test_blink_restart();
        test_enable();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
